// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: handler address, register numbers, ExcCode values,
// SR/Cause field positions and packing helpers.
package cp0_exc_ctrl_pkg;

  localparam logic [31:0] HANDLE_PC = 32'h0000_4180;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int IM_LO    = 10;
  localparam int IM_HI    = 15;
  localparam int IP_LO    = 10;
  localparam int IP_HI    = 15;
  localparam int EXC_LO   = 2;
  localparam int EXC_HI   = 6;
  localparam int CAUSE_BD = 31;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  typedef struct packed {
    logic       bd;
    logic [5:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] pack_sr(sr_t s);
    logic [31:0] w;
    w              = '0;
    w[IM_HI:IM_LO] = s.im;
    w[SR_EXL]      = s.exl;
    w[SR_IE]       = s.ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(cause_t c);
    logic [31:0] w;
    w                = '0;
    w[CAUSE_BD]      = c.bd;
    w[IP_HI:IP_LO]   = c.ip;
    w[EXC_HI:EXC_LO] = c.exc_code;
    return w;
  endfunction

  // A faulting delay-slot instruction restarts at its branch.
  function automatic logic [31:0] victim_pc(logic [31:0] pc, logic bd);
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// M-stage <-> CP0 signal bundle; the pipeline is master, CP0 is slave.
interface cp0_exc_ctrl_if;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic [31:0] epc_o;
  logic        req;

  modport master (
    output pc_m, bd_m, exc_code_m, eret_m, we, addr, wdata, hw_int,
    input  rdata, epc_o, req
  );

  modport slave (
    input  pc_m, bd_m, exc_code_m, eret_m, we, addr, wdata, hw_int,
    output rdata, epc_o, req
  );
endinterface

// File: rtl/cp0_req_arb.sv
// Combinational exception/interrupt arbiter: decides whether to trap this
// cycle and which ExcCode to record. Interrupts win over exceptions.
module cp0_req_arb
  import cp0_exc_ctrl_pkg::*;
(
  input  logic [5:0] hw_int,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic [4:0] exc_code_m,
  output logic       req,
  output logic [4:0] exc_code_sel
);

  logic int_req;
  logic exc_req;

  // EXL masks both sources so a handler is never re-entered.
  assign int_req      = (|(hw_int & im)) & ie & ~exl;
  assign exc_req      = (exc_code_m != 5'd0) & ~exl;
  assign req          = int_req | exc_req;
  assign exc_code_sel = int_req ? 5'(EXC_INT) : exc_code_m;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: holds SR/Cause/EPC/PRId,
// raises req to flush the pipeline, and services mtc0/mfc0/eret.
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h0000_0707
) (
  input  logic           clk,
  input  logic           reset,
  cp0_exc_ctrl_if.slave  bus
);

  sr_t         sr_q;
  cause_t      cause_q;
  logic [31:0] epc_q;

  logic        arb_req;
  logic [4:0]  exc_code_sel;

  cp0_req_arb u_arb (
    .hw_int       (bus.hw_int),
    .im           (sr_q.im),
    .ie           (sr_q.ie),
    .exl          (sr_q.exl),
    .exc_code_m   (bus.exc_code_m),
    .req          (arb_req),
    .exc_code_sel (exc_code_sel)
  );

  // Gate with reset so req drops at once when reset asserts mid-cycle,
  // even if a faulting instruction is still sitting in M.
  assign bus.req   = arb_req & reset;
  assign bus.epc_o = epc_q;

  // NOTE: state registers use non-blocking assignments and an asynchronous
  // active-low clear; there is no memory array here, so everything is reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= '0;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      cause_q.ip <= bus.hw_int;
      if (arb_req) begin
        // The instruction in M is flushed, so its eret/mtc0 is dropped.
        sr_q.exl         <= 1'b1;
        cause_q.exc_code <= exc_code_sel;
        cause_q.bd       <= bus.bd_m;
        epc_q            <= victim_pc(bus.pc_m, bus.bd_m);
      end else if (bus.eret_m) begin
        sr_q.exl <= 1'b0;
      end else if (bus.we) begin
        if (bus.addr == REG_SR) begin
          sr_q.im  <= bus.wdata[IM_HI:IM_LO];
          sr_q.exl <= bus.wdata[SR_EXL];
          sr_q.ie  <= bus.wdata[SR_IE];
        end else if (bus.addr == REG_EPC) begin
          epc_q <= bus.wdata;
        end
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      REG_SR:    bus.rdata = pack_sr(sr_q);
      REG_CAUSE: bus.rdata = pack_cause(cause_q);
      REG_EPC:   bus.rdata = epc_q;
      REG_PRID:  bus.rdata = PRID_VAL;
      default:   bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed vector table, random stimulus
// against a word-level CP0 model, and asynchronous reset corner cases.
module tb_cp0_exc_ctrl;

  logic clk;
  logic reset;

  cp0_exc_ctrl_if bus ();

  cp0_exc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic [5:0]  hw;
    logic [4:0]  exc;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_req;
    logic [4:0]  chk_addr;
    logic [31:0] exp_rd;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [5:0] hw, logic [4:0] exc, logic [31:0] pc, logic bd,
                              logic eret, logic we, logic [4:0] addr, logic [31:0] wdata,
                              logic exp_req, logic [4:0] chk_addr, logic [31:0] exp_rd,
                              logic [31:0] exp_epc);
    vec_t v;
    v.hw = hw; v.exc = exc; v.pc = pc; v.bd = bd; v.eret = eret; v.we = we;
    v.addr = addr; v.wdata = wdata; v.exp_req = exp_req; v.chk_addr = chk_addr;
    v.exp_rd = exp_rd; v.exp_epc = exp_epc;
    return v;
  endfunction

  task automatic drive_idle();
    bus.hw_int = '0; bus.exc_code_m = '0; bus.pc_m = '0; bus.bd_m = 1'b0;
    bus.eret_m = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
  endtask

  // Word-level reference model of SR, Cause and EPC.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic [31:0] m_read(logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_0707;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int(logic [5:0] hw);
    return (|(hw & m_sr[15:10])) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req(logic [5:0] hw, logic [4:0] exc);
    return m_int(hw) || (exc != 5'd0 && !m_sr[1]);
  endfunction

  task automatic m_step(logic [5:0] hw, logic [4:0] exc, logic [31:0] pc, logic bd,
                        logic eret, logic we, logic [4:0] a, logic [31:0] wd);
    logic [31:0] sr_n, cause_n, epc_n;
    sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
    cause_n[15:10] = hw;
    if (m_req(hw, exc)) begin
      sr_n[1]       = 1'b1;
      cause_n[6:2]  = m_int(hw) ? 5'd0 : exc;
      cause_n[31]   = bd;
      epc_n         = bd ? pc + 32'hFFFF_FFFC : pc;
    end else if (eret) begin
      sr_n[1] = 1'b0;
    end else if (we) begin
      if (a == 5'd12) sr_n = wd & 32'h0000_FC03;
      if (a == 5'd14) epc_n = wd;
    end
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
  endtask

  initial begin
    logic [4:0] exc_pool [5];
    logic [4:0] addr_pool [5];
    exc_pool  = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
    addr_pool = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7};

    //       hw      exc    pc             bd eret we addr  wdata          req chk    exp_rd          exp_epc
    tbl.push_back(mk(6'h00, 5'd12, 32'h0000_3010, 0, 0, 0, 5'd0,  32'h0,          1, 5'd13, 32'h0000_0030, 32'h0000_3010));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_3014, 0, 1, 0, 5'd0,  32'h0,          0, 5'd12, 32'h0000_0000, 32'h0000_3010));
    tbl.push_back(mk(6'h00, 5'd10, 32'h0000_3014, 1, 0, 0, 5'd0,  32'h0,          1, 5'd13, 32'h8000_0028, 32'h0000_3010));
    tbl.push_back(mk(6'h00, 5'd4,  32'h0000_3018, 0, 0, 0, 5'd0,  32'h0,          0, 5'd13, 32'h8000_0028, 32'h0000_3010));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_3018, 0, 1, 0, 5'd0,  32'h0,          0, 5'd12, 32'h0000_0000, 32'h0000_3010));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_301C, 0, 0, 1, 5'd12, 32'h0000_0401,  0, 5'd12, 32'h0000_0401, 32'h0000_3010));
    tbl.push_back(mk(6'h01, 5'd0,  32'h0000_4000, 0, 0, 0, 5'd0,  32'h0,          1, 5'd13, 32'h0000_0400, 32'h0000_4000));
    tbl.push_back(mk(6'h01, 5'd4,  32'h0000_4180, 0, 0, 0, 5'd0,  32'h0,          0, 5'd12, 32'h0000_0403, 32'h0000_4000));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_4184, 0, 1, 0, 5'd0,  32'h0,          0, 5'd12, 32'h0000_0401, 32'h0000_4000));
    tbl.push_back(mk(6'h01, 5'd8,  32'h0000_5008, 0, 1, 1, 5'd14, 32'h0000_1234,  1, 5'd13, 32'h0000_0400, 32'h0000_5008));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_4180, 0, 1, 0, 5'd0,  32'h0,          0, 5'd12, 32'h0000_0401, 32'h0000_5008));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_5008, 0, 0, 1, 5'd14, 32'h0000_1237,  0, 5'd14, 32'h0000_1237, 32'h0000_1237));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_500C, 0, 0, 1, 5'd13, 32'hFFFF_FFFF,  0, 5'd13, 32'h0000_0000, 32'h0000_1237));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_5010, 0, 0, 1, 5'd5,  32'hFFFF_FFFF,  0, 5'd5,  32'h0000_0000, 32'h0000_1237));
    tbl.push_back(mk(6'h00, 5'd5,  32'h0000_0002, 1, 0, 0, 5'd0,  32'h0,          1, 5'd13, 32'h8000_0014, 32'hFFFF_FFFE));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_4180, 0, 0, 1, 5'd12, 32'hFFFF_FFFF,  0, 5'd12, 32'h0000_FC03, 32'hFFFF_FFFE));
    tbl.push_back(mk(6'h00, 5'd0,  32'h0000_4184, 0, 0, 1, 5'd12, 32'h0000_0000,  0, 5'd12, 32'h0000_0000, 32'hFFFF_FFFE));

    // Reset state, with a pending exception held at the input.
    drive_idle();
    reset = 1'b0;
    bus.exc_code_m = 5'd12;
    repeat (2) @(negedge clk);
    #1;
    check("reset_req", 32'(bus.req), 32'd0);
    check("reset_epc_o", bus.epc_o, 32'h0);
    for (int a = 12; a <= 15; a++) begin
      bus.addr = 5'(a);
      #1;
      check($sformatf("reset_rd_%0d", a), bus.rdata, (a == 15) ? 32'h0000_0707 : 32'h0);
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b1;

    // Directed vectors: req in the drive cycle, register contents after the edge.
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.hw_int = tbl[i].hw; bus.exc_code_m = tbl[i].exc; bus.pc_m = tbl[i].pc;
      bus.bd_m = tbl[i].bd; bus.eret_m = tbl[i].eret; bus.we = tbl[i].we;
      bus.addr = tbl[i].addr; bus.wdata = tbl[i].wdata;
      #1;
      check($sformatf("vec%0d_req", i), 32'(bus.req), 32'(tbl[i].exp_req));
      @(posedge clk);
      #1;
      drive_idle();
      bus.addr = tbl[i].chk_addr;
      #1;
      check($sformatf("vec%0d_rdata", i), bus.rdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_epc_o", i), bus.epc_o, tbl[i].exp_epc);
    end

    // Random phase against the model, starting from the state the table left.
    m_sr = 32'h0; m_cause = 32'h8000_0014; m_epc = 32'hFFFF_FFFE;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.hw_int     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      bus.exc_code_m = ($urandom_range(0, 9) < 3) ? exc_pool[$urandom_range(0, 4)] : 5'd0;
      bus.pc_m       = $urandom;
      bus.bd_m       = 1'($urandom);
      bus.eret_m     = ($urandom_range(0, 4) == 0);
      bus.we         = ($urandom_range(0, 9) < 3);
      bus.addr       = addr_pool[$urandom_range(0, 4)];
      bus.wdata      = $urandom;
      #1;
      check($sformatf("rnd%0d_req", n), 32'(bus.req), 32'(m_req(bus.hw_int, bus.exc_code_m)));
      check($sformatf("rnd%0d_rdata", n), bus.rdata, m_read(bus.addr));
      check($sformatf("rnd%0d_epc_o", n), bus.epc_o, m_epc);
      m_step(bus.hw_int, bus.exc_code_m, bus.pc_m, bus.bd_m, bus.eret_m, bus.we, bus.addr, bus.wdata);
      @(posedge clk);
    end

    // Reset asserted mid-cycle while req is high.
    @(negedge clk);
    drive_idle();
    reset = 1'b0;
    #1;
    check("midrst_clear_epc", bus.epc_o, 32'h0);
    reset = 1'b1;
    bus.exc_code_m = 5'd12;
    bus.pc_m = 32'h0000_0100;
    #1;
    check("midrst_req_before", 32'(bus.req), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_req_dropped", 32'(bus.req), 32'd0);
    bus.addr = 5'd13;
    #1;
    check("midrst_cause", bus.rdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_req", 32'(bus.req), 32'd1);
    @(posedge clk);
    #1;
    check("post_rst_epc", bus.epc_o, 32'h0000_0100);
    check("post_rst_cause", bus.rdata, 32'h0000_0030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception/interrupt controller for the P7 five-stage MIPS pipeline. It sits beside the M stage, examines the instruction leaving M each cycle, and raises `req` to flush every pipeline register and steer fetch to the handler at `handlePC`. It also holds SR/Cause/EPC/PRId, and services `mtc0`, `mfc0` and `eret`. It produces the `req` that the W-stage register and the other stage registers consume.

## Interface
- `PRID_VAL`, 32'h0000_0707, constant read from PRId.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `pc_m`  in  32  PC of the instruction in M; bubbles carry the PC of the next real instruction.
- `bd_m`  in  1  instruction in M is in a branch delay slot.
- `exc_code_m`  in  5  accumulated exception code from F/D/E/M; 0 = none.
- `eret_m`  in  1  `eret` in M.
- `we`  in  1  `mtc0` in M.
- `addr`  in  5  CP0 register number (rd field).
- `wdata`  in  32  `mtc0` data.
- `hw_int`  in  6  external interrupt lines, level-sensitive.
- `rdata`  out  32  `mfc0` read data, combinational.
- `epc_o`  out  32  current EPC, used by NPC on `eret`.
- `req`  out  1  exception/interrupt taken this cycle, combinational.

## Operation
- The registers are SR(12), Cause(13), EPC(14) and PRId(15). Any other `addr` reads 0, and writes to it are ignored.
- SR fields are IM[15:10], EXL[1] and IE[0]. All other bits read 0.
- Cause fields are BD[31], IP[15:10] and ExcCode[6:2]. All other bits read 0. Cause is not writable by `mtc0`.
- IP[15:10] is loaded from `hw_int` every cycle.
- `int_req` = |(`hw_int` & IM) & IE & !EXL.
- `exc_req` = (`exc_code_m` != 0) & !EXL.
- `req` = `int_req` | `exc_req`.
- Interrupt beats exception. On an interrupt, ExcCode is set to 0.
- On `req` at the clock edge, the controller does all of the following:
  - EXL is set to 1.
  - ExcCode is loaded with 0 (interrupt) or `exc_code_m`.
  - BD is loaded with `bd_m`.
  - EPC is loaded with `bd_m` ? `pc_m`−4 : `pc_m`, with PC arithmetic modulo 2^32 and the low 2 bits kept.
- Priority at a clock edge is `req` > `eret_m` > `mtc0`. When `req` fires, a simultaneous `eret_m` or `we` is discarded, because the instruction in M is flushed.
- `eret_m` without `req` clears EXL. IE is untouched.
- `mtc0` to SR writes IM, EXL and IE.
- `mtc0` to EPC writes the full 32 bits with no alignment.
- `rdata` presents the current register contents combinationally. It does not reflect a same-cycle write.
- While EXL=1, `req` never asserts, so nested exceptions are masked.

## Timing
- Reset value of every output is `rdata`=0 (when addr≠15), `epc_o`=0 and `req`=0.
- Reset value of every internal register is SR=0, Cause=0 and EPC=0.
- `req` is combinational, with zero-cycle latency from its inputs. The flush and the PC redirect happen at the same edge that latches EPC.
- An `mtc0` write is visible on `rdata`/`epc_o` from the cycle after the edge.
- IP lags `hw_int` by one cycle. The `int_req` decision uses live `hw_int`, not IP.
- If `reset` asserts mid-cycle while `req`=1, state clears asynchronously and `req` drops.
- After `reset` deasserts, normal operation starts at the first rising edge.
- The block has no stall input. M-stage stalls are removed upstream by sending bubbles.

## Structure
- The shared `defines.v` package holds:
  - `handlePC` (32'h0000_4180).
  - The register numbers 12/13/14/15.
  - The ExcCode values: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12.
  - The SR/Cause field bit positions.
- One sub-module is natural: `cp0_req_arb`. It is a combinational arbiter computing `int_req`, `exc_req`, `req` and the selected ExcCode.
- The register file and update logic stay in the top module.

## Test plan
- Reset: hold `reset`=0, then release. Required: SR=0, Cause=0, EPC=0, `req`=0, and reading addr=15 returns 32'h0000_0707.
- Exception: `exc_code_m`=12, `pc_m`=32'h0000_3010, `bd_m`=0. Required: `req`=1 in the same cycle. Next cycle: EPC=32'h0000_3010, ExcCode=12, EXL=1.
- Delay slot: `exc_code_m`=10, `pc_m`=32'h0000_3014, `bd_m`=1. Required: EPC=32'h0000_3010 and BD=1.
- Interrupt masking: first write SR=32'h0000_0401 and drive `hw_int`=6'b000001. Required: `req`=1, and afterwards ExcCode=0 and EXL=1. Then with EXL=1, drive `exc_code_m`=4. Required: `req`=0.
- Priority: interrupt pending while `exc_code_m`=8, `we`=1 (EPC ← 32'h1234) and `eret_m`=1, all in the same cycle. Required: ExcCode=0, EPC=`pc_m`, and the write and eret are dropped.
- eret: with EXL=1, pulse `eret_m`. Required: EXL=0 next cycle, IE unchanged, and `epc_o` equal to the latched EPC.
